// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 INCR-burst memory responder; define AXI4_SLV_RANGE_CHECK_EN to reject out-of-range beats with SLVERR instead of wrapping
module axi4_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  input  logic                  WLAST,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  output logic                  RLAST,
  input  logic                  RREADY
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB = $clog2(BYTES);
  localparam int IW = ADDR_WIDTH - LB;
  localparam int MW = $clog2(MEMORY_DEPTH);
  localparam logic [IW:0] DEPTH = (IW + 1)'(MEMORY_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LB);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  w_state_t w_st, w_nx;
  r_state_t r_st, r_nx;
  logic [ADDR_WIDTH-1:0] w_addr, w_addr_n, r_addr, r_addr_n;
  logic [7:0] w_len, w_len_n, w_cnt, w_cnt_n, r_len, r_len_n, r_cnt, r_cnt_n;
  logic [2:0] w_size, w_size_n, r_size, r_size_n;
  logic w_err, w_err_n, r_err, r_err_n, w_oor, r_oor, w_en, w_last;
  logic awready_n, wready_n, bvalid_n, arready_n, rvalid_n, rlast_n;
  logic [1:0] bresp_n, rresp_n;
  logic [MW-1:0] w_idx, r_idx;

  // Oversized beats still advance by one full word
  function automatic logic [ADDR_WIDTH-1:0] step(input logic [2:0] size);
    return size > MAX_SIZE ? ADDR_WIDTH'(BYTES) : ADDR_WIDTH'(1) << size;
  endfunction

  function automatic logic [MW-1:0] wrap(input logic [ADDR_WIDTH-1:0] a);
    return MW'({1'b0, a[ADDR_WIDTH-1:LB]} % DEPTH);
  endfunction

  assign w_idx = wrap(w_addr);
  assign r_idx = wrap(r_addr);
  assign w_last = w_cnt == w_len;
`ifdef AXI4_SLV_RANGE_CHECK_EN
  assign w_oor = {1'b0, w_addr[ADDR_WIDTH-1:LB]} >= DEPTH;
  assign r_oor = {1'b0, r_addr[ADDR_WIDTH-1:LB]} >= DEPTH;
`else
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  // Write channel next state, datapath and registered outputs
  always_comb begin
    w_nx = w_st;
    w_addr_n = w_addr;
    w_len_n = w_len;
    w_size_n = w_size;
    w_cnt_n = w_cnt;
    w_err_n = w_err;
    awready_n = AWREADY;
    wready_n = WREADY;
    bvalid_n = BVALID;
    bresp_n = BRESP;
    w_en = 1'b0;
    case (w_st)
      W_IDLE: begin
        awready_n = !(AWVALID && AWREADY);
        if (AWVALID && AWREADY) begin
          w_addr_n = AWADDR;
          w_len_n = AWLEN;
          w_size_n = AWSIZE;
          w_cnt_n = '0;
          w_err_n = AWSIZE > MAX_SIZE;
          wready_n = 1'b1;
          w_nx = W_DATA;
        end
      end
      W_DATA: if (WVALID && WREADY) begin
        w_en = !w_oor;
        w_err_n = w_err || w_oor || (WLAST != w_last);
        w_addr_n = w_addr + step(w_size);
        w_cnt_n = w_cnt + 8'd1;
        if (w_last) begin
          wready_n = 1'b0;
          bvalid_n = 1'b1;
          bresp_n = w_err_n ? SLVERR : OKAY;
          w_nx = W_RESP;
        end
      end
      W_RESP: if (BREADY) begin
        bvalid_n = 1'b0;
        bresp_n = OKAY;
        awready_n = 1'b1;
        w_nx = W_IDLE;
      end
      default: w_nx = W_IDLE;
    endcase
  end

  // Read channel next state, datapath and registered outputs
  always_comb begin
    r_nx = r_st;
    r_addr_n = r_addr;
    r_len_n = r_len;
    r_size_n = r_size;
    r_cnt_n = r_cnt;
    r_err_n = r_err;
    arready_n = ARREADY;
    rvalid_n = RVALID;
    rlast_n = RLAST;
    rresp_n = RRESP;
    case (r_st)
      R_IDLE: begin
        arready_n = !(ARVALID && ARREADY);
        if (ARVALID && ARREADY) begin
          r_addr_n = ARADDR;
          r_len_n = ARLEN;
          r_size_n = ARSIZE;
          r_cnt_n = '0;
          r_err_n = ARSIZE > MAX_SIZE;
          r_nx = R_FETCH;
        end
      end
      R_FETCH: begin
        rvalid_n = 1'b1;
        rlast_n = r_cnt == r_len;
        rresp_n = (r_err || r_oor) ? SLVERR : OKAY;
        r_nx = R_DATA;
      end
      R_DATA: if (RREADY) begin
        rvalid_n = 1'b0;
        if (RLAST) begin
          rlast_n = 1'b0;
          rresp_n = OKAY;
          arready_n = 1'b1;
          r_nx = R_IDLE;
        end else begin
          r_addr_n = r_addr + step(r_size);
          r_cnt_n = r_cnt + 8'd1;
          r_nx = R_FETCH;
        end
      end
      default: r_nx = R_IDLE;
    endcase
  end

  // State, burst context and channel outputs; reset abandons any burst in flight
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      w_st <= W_IDLE;
      r_st <= R_IDLE;
      {w_addr, w_len, w_size, w_cnt, w_err} <= '0;
      {r_addr, r_len, r_size, r_cnt, r_err} <= '0;
      {AWREADY, WREADY, BVALID, BRESP} <= '0;
      {ARREADY, RVALID, RLAST, RRESP} <= '0;
    end else begin
      w_st <= w_nx;
      r_st <= r_nx;
      {w_addr, w_len, w_size, w_cnt, w_err} <= {w_addr_n, w_len_n, w_size_n, w_cnt_n, w_err_n};
      {r_addr, r_len, r_size, r_cnt, r_err} <= {r_addr_n, r_len_n, r_size_n, r_cnt_n, r_err_n};
      {AWREADY, WREADY, BVALID, BRESP} <= {awready_n, wready_n, bvalid_n, bresp_n};
      {ARREADY, RVALID, RLAST, RRESP} <= {arready_n, rvalid_n, rlast_n, rresp_n};
    end

  // Fetch cycle reads the array into RDATA, which then holds through any stall
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) RDATA <= '0;
    else if (r_st == R_FETCH) RDATA <= r_oor ? '0 : mem[r_idx];

  // Array write port; a same-cycle read of this word sees the old contents
  always_ff @(posedge ACLK)
    if (w_en) mem[w_idx] <= WDATA;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: table-driven write/read-back vectors plus stall, WLAST, range and reset sequences
module tb_axi4_mem_slave;
  localparam logic [1:0] OK = 2'b00, SE = 2'b10;
  logic ACLK = 1'b0, ARESETn;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0] AWLEN, ARLEN;
  logic [2:0] AWSIZE, ARSIZE;
  logic AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0] BRESP, RRESP;
  int total = 0, passed = 0;
  logic [31:0] ex_data [16];
  logic [1:0] ex_resp;

  typedef struct {
    logic [15:0] wa;
    logic [7:0] wl;
    logic [2:0] ws;
    logic [31:0] wd;
    logic [1:0] eb;
    logic [15:0] ra;
    logic [7:0] rl;
    logic [2:0] rs;
    logic [1:0] er;
    logic [31:0] e [4];
  } vec_t;
  vec_t vecs [8];
  int nv = 0;

  axi4_mem_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic tmo(input string nm);
    total++;
    $display("FAIL %s: timeout waiting for handshake", nm);
  endtask

  task automatic add(input logic [15:0] wa, input logic [7:0] wl, input logic [2:0] ws,
                     input logic [31:0] wd, input logic [1:0] eb, input logic [15:0] ra,
                     input logic [7:0] rl, input logic [2:0] rs, input logic [1:0] er,
                     input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] e3);
    vecs[nv].wa = wa; vecs[nv].wl = wl; vecs[nv].ws = ws; vecs[nv].wd = wd; vecs[nv].eb = eb;
    vecs[nv].ra = ra; vecs[nv].rl = rl; vecs[nv].rs = rs; vecs[nv].er = er;
    vecs[nv].e[0] = e0; vecs[nv].e[1] = e1; vecs[nv].e[2] = e2; vecs[nv].e[3] = e3;
    nv++;
  endtask

  // Beat i carries d0+i; WLAST is raised only on beat wl_at; gap idle cycles between beats; BREADY withheld bh cycles
  task automatic do_write(input string tag, input logic [15:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [31:0] d0, input int wl_at,
                          input int gap, input int bh, input logic [1:0] eb);
    int n;
    AWADDR = a; AWLEN = l; AWSIZE = s; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin tick(); n++; end
    if (!AWREADY) begin tmo({tag, "_awready"}); AWVALID = 1'b0; return; end
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) repeat (gap) tick();
      WDATA = d0 + 32'(i); WLAST = (i == wl_at); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin tick(); n++; end
      if (!WREADY) begin tmo({tag, "_wready"}); WVALID = 1'b0; WLAST = 1'b0; return; end
      tick();
      WVALID = 1'b0; WLAST = 1'b0;
    end
    chk({tag, "_bvalid"}, BVALID, 1);
    chk({tag, "_wready_off"}, WREADY, 0);
    chk({tag, "_bresp"}, BRESP, eb);
    repeat (bh) begin
      tick();
      chk({tag, "_bvalid_hold"}, BVALID, 1);
      chk({tag, "_bresp_hold"}, BRESP, eb);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk({tag, "_bvalid_clr"}, BVALID, 0);
  endtask

  // Compares each beat against ex_data/ex_resp; beat sb is stalled sn cycles with RREADY low
  task automatic do_read(input string tag, input logic [15:0] a, input logic [7:0] l,
                         input logic [2:0] s, input int sb, input int sn);
    int n, lat;
    ARADDR = a; ARLEN = l; ARSIZE = s; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin tick(); n++; end
    if (!ARREADY) begin tmo({tag, "_arready"}); ARVALID = 1'b0; return; end
    tick();
    ARVALID = 1'b0;
    lat = 1;
    for (int i = 0; i <= int'(l); i++) begin
      n = 0;
      while (!RVALID && n < 50) begin tick(); n++; if (i == 0) lat++; end
      if (!RVALID) begin tmo({tag, "_rvalid"}); return; end
      if (i == 0) chk({tag, "_latency"}, 64'(lat), 2);
      chk({tag, "_rdata"}, RDATA, ex_data[i]);
      chk({tag, "_rresp"}, RRESP, ex_resp);
      chk({tag, "_rlast"}, RLAST, i == int'(l));
      if (i == sb) repeat (sn) begin
        tick();
        chk({tag, "_stall_rvalid"}, RVALID, 1);
        chk({tag, "_stall_rdata"}, RDATA, ex_data[i]);
        chk({tag, "_stall_rlast"}, RLAST, i == int'(l));
      end
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    chk({tag, "_rvalid_clr"}, RVALID, 0);
  endtask

  initial begin
    int n;
    ARESETn = 1'b0;
    {AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY} = '0;
    {ARADDR, ARLEN, ARSIZE, ARVALID, RREADY} = '0;
    add(16'h0000, 0, 2, 32'h1111_0000, OK, 16'h0000, 0, 2, OK, 32'h1111_0000, 0, 0, 0);
    add(16'h0010, 0, 2, 32'hDEAD_BEEF, OK, 16'h0010, 0, 2, OK, 32'hDEAD_BEEF, 0, 0, 0);
    add(16'h0100, 3, 2, 32'd1, OK, 16'h0100, 3, 2, OK, 32'd1, 32'd2, 32'd3, 32'd4);
    add(16'h0200, 1, 3, 32'hA0, SE, 16'h0200, 1, 2, OK, 32'hA0, 32'hA1, 0, 0);
    add(16'h0300, 3, 1, 32'h10, OK, 16'h0300, 1, 2, OK, 32'h11, 32'h13, 0, 0);
    add(16'h0400, 1, 2, 32'h50, OK, 16'h0400, 1, 3, SE, 32'h50, 32'h51, 0, 0);
    add(16'h0500, 1, 0, 32'h60, OK, 16'h0500, 0, 2, OK, 32'h61, 0, 0, 0);
    tick();
    tick();
    chk("rst_readies", {AWREADY, WREADY, ARREADY}, 0);
    chk("rst_valids", {BVALID, RVALID, RLAST}, 0);
    chk("rst_resps", {BRESP, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    ARESETn = 1'b1;
    tick();
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_arready", ARREADY, 1);

    for (int v = 0; v < nv; v++) begin
      do_write($sformatf("vec%0d_wr", v), vecs[v].wa, vecs[v].wl, vecs[v].ws, vecs[v].wd,
               int'(vecs[v].wl), 0, 0, vecs[v].eb);
      for (int i = 0; i < 4; i++) ex_data[i] = vecs[v].e[i];
      ex_resp = vecs[v].er;
      do_read($sformatf("vec%0d_rd", v), vecs[v].ra, vecs[v].rl, vecs[v].rs, -1, 0);
    end

    for (int i = 0; i < 4; i++) ex_data[i] = 32'(i + 1);
    ex_resp = OK;
    do_read("stall_rd", 16'h0100, 3, 2, 1, 5);

    do_write("gap_wr", 16'h0600, 3, 2, 32'h70, 3, 2, 0, OK);
    for (int i = 0; i < 4; i++) ex_data[i] = 32'h70 + 32'(i);
    do_read("gap_rd", 16'h0600, 3, 2, -1, 0);

    do_write("wlast_wr", 16'h0700, 2, 2, 32'h80, 1, 0, 4, SE);
    for (int i = 0; i < 3; i++) ex_data[i] = 32'h80 + 32'(i);
    do_read("wlast_rd", 16'h0700, 2, 2, -1, 0);

`ifdef AXI4_SLV_RANGE_CHECK_EN
    do_write("oor_wr", 16'h1000, 0, 2, 32'hCAFE_0000, 0, 0, 0, SE);
    ex_data[0] = 32'h1111_0000; ex_resp = OK;
    do_read("oor_word0", 16'h0000, 0, 2, -1, 0);
    ex_data[0] = 32'h0; ex_resp = SE;
    do_read("oor_rd", 16'h1000, 0, 2, -1, 0);
`else
    do_write("oor_wr", 16'h1000, 0, 2, 32'hCAFE_0000, 0, 0, 0, OK);
    ex_data[0] = 32'hCAFE_0000; ex_resp = OK;
    do_read("oor_word0", 16'h0000, 0, 2, -1, 0);
    do_read("oor_rd", 16'h1000, 0, 2, -1, 0);
`endif

    ARADDR = 16'h0100; ARLEN = 3; ARSIZE = 2; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin tick(); n++; end
    if (!ARREADY) tmo("midrst_arready");
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 50) begin tick(); n++; end
    if (!RVALID) tmo("midrst_rvalid");
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    tick();
    chk("midrst_in_burst", RVALID, 1);
    chk("midrst_beat2", RDATA, 2);
    #2 ARESETn = 1'b0;
    #1 chk("midrst_rvalid_low", RVALID, 0);
    chk("midrst_rdata_low", RDATA, 0);
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
    tick();
    chk("midrst_release_rvalid", RVALID, 0);
    chk("midrst_release_arready", ARREADY, 1);
    chk("midrst_release_awready", AWREADY, 1);
    ex_data[0] = 32'hDEAD_BEEF; ex_resp = OK;
    do_read("midrst_rd", 16'h0010, 0, 2, -1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
